axil_cmd_master: RTL and testbench

- Upstream neighbour of the s3 AXI4-Lite memory-mapped slave. Converts a simple single-outstanding command/response stream into AXI4-Lite master transactions on an m3_axi_* port set that wires 1:1 onto the slave's s3_axi_* ports.
- Serialises writes and reads, one transaction in flight. Guards B/R waits with a timeout counter so a hung slave cannot stall the command source forever.

---
 rtl/axil_pkg.sv | 25 ++
 rtl/axil_timeout_ctr.sv | 51 +++++
 rtl/axil_cmd_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// axil_pkg
//   Shared definitions for the AXI4-Lite command master and its helpers:
//   default channel widths, the AXI response codes used on bresp/rresp, the
//   local timeout response code, and the master FSM state encoding.
package axil_pkg;

  localparam int AXIL_DATA_WIDTH = 32;
  localparam int AXIL_ADDR_WIDTH = 8;
  localparam int AXIL_RESP_WIDTH = 3;

  localparam logic [AXIL_RESP_WIDTH-1:0] RESP_OKAY    = 3'd0;
  localparam logic [AXIL_RESP_WIDTH-1:0] RESP_SLVERR  = 3'd2;
  localparam logic [AXIL_RESP_WIDTH-1:0] RESP_DECERR  = 3'd3;
  localparam logic [AXIL_RESP_WIDTH-1:0] RESP_TIMEOUT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_AW_W = 3'd1,
    S_WR_B    = 3'd2,
    S_RD_AR   = 3'd3,
    S_RD_R    = 3'd4,
    S_RSP     = 3'd5
  } axil_state_e;

endpackage

// File: rtl/axil_timeout_ctr.sv
// axil_timeout_ctr
//   Wait-cycle counter for response phases. Cleared by clr_i, counts each
//   cycle en_i is high, and flags expire_o during the cycle in which the
//   count has reached TIMEOUT_CYCLES-1 (the last cycle the caller may wait).
//   TIMEOUT_CYCLES = 0 disables expiry entirely.
// Ports:
//   clk_i     clock, rising edge
//   srst_i    synchronous active-high reset
//   clr_i     restart the count at 0 on the next edge
//   en_i      caller is waiting this cycle
//   expire_o  wait budget used up this cycle
module axil_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit ENABLED = (TIMEOUT_CYCLES > 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);

  // Count holds at LAST so it never wraps if the caller keeps waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_last) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = ENABLED && en_i && !clr_i && at_last;

endmodule

// File: rtl/axil_cmd_master.sv
// axil_cmd_master
//   Turns a single-outstanding command/response stream into AXI4-Lite
//   master transactions on the m3_axi_* port set. One transaction in
//   flight; B and R waits are bounded by a timeout that returns
//   RESP_TIMEOUT (all ones) instead of hanging the command source.
//   Every AXI and rsp output comes straight from a register.
// Ports:
//   m3_axi_aclk / m3_axi_areset   clock, synchronous active-high reset
//   cmd_valid/ready/we/addr/wdata/wstrb   command in
//   rsp_valid/ready/we/rdata/resp         response out
//   m3_axi_aw*, m3_axi_w*, m3_axi_b*      write channels
//   m3_axi_ar*, m3_axi_r*                 read channels
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH     = AXIL_DATA_WIDTH,
  parameter int ADDR_WIDTH     = AXIL_ADDR_WIDTH,
  parameter int RESP_WIDTH     = AXIL_RESP_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    m3_axi_aclk,
  input  logic                    m3_axi_areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_we,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [RESP_WIDTH-1:0]   rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m3_axi_awaddr,
  output logic                    m3_axi_awvalid,
  input  logic                    m3_axi_awready,
  output logic [DATA_WIDTH-1:0]   m3_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m3_axi_wstrb,
  output logic                    m3_axi_wvalid,
  input  logic                    m3_axi_wready,
  input  logic [RESP_WIDTH-1:0]   m3_axi_bresp,
  input  logic                    m3_axi_bvalid,
  output logic                    m3_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m3_axi_araddr,
  output logic                    m3_axi_arvalid,
  input  logic                    m3_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m3_axi_rdata,
  input  logic [RESP_WIDTH-1:0]   m3_axi_rresp,
  input  logic                    m3_axi_rvalid,
  output logic                    m3_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [RESP_WIDTH-1:0] RESP_TO = {RESP_WIDTH{1'b1}};

  axil_state_e           state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [RESP_WIDTH-1:0] rsp_resp_q, rsp_resp_d;

  logic ctr_clr, ctr_en, ctr_expire;
  logic aw_hs, w_hs, aw_fin, w_fin;

  assign aw_hs  = awvalid_q && m3_axi_awready;
  assign w_hs   = wvalid_q && m3_axi_wready;
  assign aw_fin = aw_done_q || aw_hs;
  assign w_fin  = w_done_q || w_hs;
  assign ctr_en = (state_q == S_WR_B) || (state_q == S_RD_R);

  axil_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (m3_axi_aclk),
    .srst_i  (m3_axi_areset),
    .clr_i   (ctr_clr),
    .en_i    (ctr_en),
    .expire_o(ctr_expire)
  );

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    ctr_clr     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          we_d        = cmd_we;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          state_d     = cmd_we ? S_WR_AW_W : S_RD_AR;
        end
      end

      S_WR_AW_W: begin
        // A channel not yet raised (valid low, not done) is raised here;
        // a raised one holds until its own ready and then stays low.
        awvalid_d = awvalid_q ? !m3_axi_awready : !aw_done_q;
        wvalid_d  = wvalid_q  ? !m3_axi_wready  : !w_done_q;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_fin && w_fin) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b1;
          ctr_clr   = 1'b1;
          state_d   = S_WR_B;
        end
      end

      S_WR_B: begin
        // A B handshake in the expiry cycle takes priority over the timeout.
        if (bready_q && m3_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_resp_d  = m3_axi_bresp;
          rsp_rdata_d = '0;
          state_d     = S_RSP;
        end else if (ctr_expire) begin
          bready_d    = 1'b0;
          rsp_resp_d  = RESP_TO;
          rsp_rdata_d = '0;
          state_d     = S_RSP;
        end
      end

      S_RD_AR: begin
        arvalid_d = arvalid_q ? !m3_axi_arready : 1'b1;
        if (arvalid_q && m3_axi_arready) begin
          rready_d = 1'b1;
          ctr_clr  = 1'b1;
          state_d  = S_RD_R;
        end
      end

      S_RD_R: begin
        if (rready_q && m3_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m3_axi_rdata;
          rsp_resp_d  = m3_axi_rresp;
          state_d     = S_RSP;
        end else if (ctr_expire) begin
          rready_d    = 1'b0;
          rsp_rdata_d = '0;
          rsp_resp_d  = RESP_TO;
          state_d     = S_RSP;
        end
      end

      S_RSP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge m3_axi_aclk) begin
    if (m3_axi_areset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // One address register serves both AW and AR; only one is ever valid.
  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_we         = we_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign m3_axi_awaddr  = addr_q;
  assign m3_axi_awvalid = awvalid_q;
  assign m3_axi_wdata   = wdata_q;
  assign m3_axi_wstrb   = wstrb_q;
  assign m3_axi_wvalid  = wvalid_q;
  assign m3_axi_bready  = bready_q;
  assign m3_axi_araddr  = addr_q;
  assign m3_axi_arvalid = arvalid_q;
  assign m3_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master
//   Directed bench: a small AXI4-Lite slave model with per-channel latency
//   knobs, handshake monitors, and hand-computed expectations.
module tb_axil_cmd_master;

  logic        m3_axi_aclk = 1'b0;
  logic        m3_axi_areset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_resp;
  logic [7:0]  m3_axi_awaddr, m3_axi_araddr;
  logic        m3_axi_awvalid, m3_axi_awready;
  logic [31:0] m3_axi_wdata, m3_axi_rdata;
  logic [3:0]  m3_axi_wstrb;
  logic        m3_axi_wvalid, m3_axi_wready;
  logic [2:0]  m3_axi_bresp, m3_axi_rresp;
  logic        m3_axi_bvalid, m3_axi_bready;
  logic        m3_axi_arvalid, m3_axi_arready;
  logic        m3_axi_rvalid, m3_axi_rready;

  always #5 m3_axi_aclk = ~m3_axi_aclk;

  axil_cmd_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .m3_axi_aclk(m3_axi_aclk), .m3_axi_areset(m3_axi_areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m3_axi_awaddr(m3_axi_awaddr), .m3_axi_awvalid(m3_axi_awvalid),
    .m3_axi_awready(m3_axi_awready),
    .m3_axi_wdata(m3_axi_wdata), .m3_axi_wstrb(m3_axi_wstrb),
    .m3_axi_wvalid(m3_axi_wvalid), .m3_axi_wready(m3_axi_wready),
    .m3_axi_bresp(m3_axi_bresp), .m3_axi_bvalid(m3_axi_bvalid),
    .m3_axi_bready(m3_axi_bready),
    .m3_axi_araddr(m3_axi_araddr), .m3_axi_arvalid(m3_axi_arvalid),
    .m3_axi_arready(m3_axi_arready),
    .m3_axi_rdata(m3_axi_rdata), .m3_axi_rresp(m3_axi_rresp),
    .m3_axi_rvalid(m3_axi_rvalid), .m3_axi_rready(m3_axi_rready)
  );

  // ---------------- slave model ----------------
  int aw_lat, w_lat, ar_lat, r_lat, b_lat;
  int b_never;
  logic [2:0] b_resp_k, r_resp_k;
  logic mem_load;

  logic [31:0] mem [0:63];
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_got, w_got, b_pend, r_pend;
  logic [7:0] aw_addr_l, r_addr_l;
  logic [31:0] w_data_l, merged;
  logic [3:0] w_strb_l;
  logic aw_ok, w_ok;
  logic [7:0] wa;
  logic [31:0] wd;
  logic [3:0] ws;

  assign m3_axi_awready = (aw_cnt >= aw_lat);
  assign m3_axi_wready  = (w_cnt >= w_lat);
  assign m3_axi_arready = (ar_cnt >= ar_lat);
  assign aw_ok = aw_got || (m3_axi_awvalid && m3_axi_awready);
  assign w_ok  = w_got || (m3_axi_wvalid && m3_axi_wready);
  assign wa = aw_got ? aw_addr_l : m3_axi_awaddr;
  assign wd = w_got ? w_data_l : m3_axi_wdata;
  assign ws = w_got ? w_strb_l : m3_axi_wstrb;

  always_comb begin
    merged = mem[wa[7:2]];
    for (int b = 0; b < 4; b++) begin
      if (ws[b]) merged[8*b +: 8] = wd[8*b +: 8];
    end
  end

  always @(posedge m3_axi_aclk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end
    if (m3_axi_areset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      m3_axi_bvalid <= 1'b0; m3_axi_rvalid <= 1'b0;
      m3_axi_bresp <= 3'd0; m3_axi_rresp <= 3'd0; m3_axi_rdata <= 32'd0;
    end else begin
      if (m3_axi_awvalid && m3_axi_awready) begin
        aw_got <= 1'b1; aw_addr_l <= m3_axi_awaddr; aw_cnt <= 0;
      end else if (m3_axi_awvalid) aw_cnt <= aw_cnt + 1;
      if (m3_axi_wvalid && m3_axi_wready) begin
        w_got <= 1'b1; w_data_l <= m3_axi_wdata; w_strb_l <= m3_axi_wstrb; w_cnt <= 0;
      end else if (m3_axi_wvalid) w_cnt <= w_cnt + 1;
      if (m3_axi_bvalid && m3_axi_bready) m3_axi_bvalid <= 1'b0;
      if (b_pend) begin
        if (b_cnt >= b_lat) begin
          m3_axi_bvalid <= 1'b1; m3_axi_bresp <= b_resp_k; b_pend <= 1'b0;
        end else b_cnt <= b_cnt + 1;
      end
      if (aw_ok && w_ok) begin
        mem[wa[7:2]] <= merged;
        aw_got <= 1'b0; w_got <= 1'b0;
        if (b_never == 0) begin
          if (b_lat == 0) begin
            m3_axi_bvalid <= 1'b1; m3_axi_bresp <= b_resp_k;
          end else begin
            b_pend <= 1'b1; b_cnt <= 1;
          end
        end
      end
      if (m3_axi_rvalid && m3_axi_rready) m3_axi_rvalid <= 1'b0;
      if (r_pend) begin
        if (r_cnt >= r_lat) begin
          m3_axi_rvalid <= 1'b1; m3_axi_rdata <= mem[r_addr_l[7:2]];
          m3_axi_rresp <= r_resp_k; r_pend <= 1'b0;
        end else r_cnt <= r_cnt + 1;
      end
      if (m3_axi_arvalid && m3_axi_arready) begin
        ar_cnt <= 0;
        if (r_lat == 0) begin
          m3_axi_rvalid <= 1'b1; m3_axi_rdata <= mem[m3_axi_araddr[7:2]];
          m3_axi_rresp <= r_resp_k;
        end else begin
          r_pend <= 1'b1; r_cnt <= 1; r_addr_l <= m3_axi_araddr;
        end
      end else if (m3_axi_arvalid) ar_cnt <= ar_cnt + 1;
    end
  end

  // ---------------- monitors ----------------
  int cyc, acc_cyc, aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc, rsp_cyc;
  int n_aw, n_w, n_b, n_ar, n_r, n_rsp, n_bready_hi, stab_err;
  logic [7:0] ar_addr_seen;
  logic rsp_prev, aw_pend_p, w_pend_p, ar_pend_p;
  logic [7:0] awaddr_p, araddr_p;
  logic [31:0] wdata_p;

  always @(posedge m3_axi_aclk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) acc_cyc <= cyc;
    if (m3_axi_awvalid && m3_axi_awready) begin n_aw <= n_aw + 1; aw_cyc <= cyc; end
    if (m3_axi_wvalid && m3_axi_wready) begin n_w <= n_w + 1; w_cyc <= cyc; end
    if (m3_axi_bvalid && m3_axi_bready) begin n_b <= n_b + 1; b_cyc <= cyc; end
    if (m3_axi_arvalid && m3_axi_arready) begin
      n_ar <= n_ar + 1; ar_cyc <= cyc; ar_addr_seen <= m3_axi_araddr;
    end
    if (m3_axi_rvalid && m3_axi_rready) begin n_r <= n_r + 1; r_cyc <= cyc; end
    if (rsp_valid && !rsp_prev) begin n_rsp <= n_rsp + 1; rsp_cyc <= cyc; end
    rsp_prev <= rsp_valid;
    if (m3_axi_bready) n_bready_hi <= n_bready_hi + 1;
    // A valid waiting on ready must still be high with the same payload.
    if (!m3_axi_areset) begin
      if (aw_pend_p && (!m3_axi_awvalid || m3_axi_awaddr != awaddr_p)) stab_err <= stab_err + 1;
      if (w_pend_p && (!m3_axi_wvalid || m3_axi_wdata != wdata_p)) stab_err <= stab_err + 1;
      if (ar_pend_p && (!m3_axi_arvalid || m3_axi_araddr != araddr_p)) stab_err <= stab_err + 1;
    end
    aw_pend_p <= !m3_axi_areset && m3_axi_awvalid && !m3_axi_awready;
    w_pend_p  <= !m3_axi_areset && m3_axi_wvalid && !m3_axi_wready;
    ar_pend_p <= !m3_axi_areset && m3_axi_arvalid && !m3_axi_arready;
    awaddr_p <= m3_axi_awaddr; wdata_p <= m3_axi_wdata; araddr_p <= m3_axi_araddr;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic we, input logic [7:0] addr, input logic [31:0] data);
    int n;
    n = 0;
    @(negedge m3_axi_aclk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = 4'hF;
    while (!cmd_ready && n < 100) begin @(negedge m3_axi_aclk); n++; end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge m3_axi_aclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, output logic we_o, output logic [31:0] rdata_o,
                          output logic [2:0] resp_o);
    int n;
    bit stable;
    n = 0;
    @(negedge m3_axi_aclk);
    while (!rsp_valid && n < 200) begin @(negedge m3_axi_aclk); n++; end
    check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    we_o = rsp_we; rdata_o = rsp_rdata; resp_o = rsp_resp;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge m3_axi_aclk);
      if (!rsp_valid || rsp_rdata != rdata_o || rsp_resp != resp_o || rsp_we != we_o || cmd_ready)
        stable = 1'b0;
    end
    if (hold > 0) check("rsp_hold_stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(negedge m3_axi_aclk);
    rsp_ready = 1'b0;
    check("rsp_done_cmd_ready", 32'({rsp_valid, cmd_ready}), 32'b01);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        r_we;
    logic [31:0] r_data;
    logic [2:0]  r_resp;
    int          base_aw, base_w, base_b, base_rsp, base_bh;

    aw_lat = 0; w_lat = 0; ar_lat = 0; r_lat = 0; b_lat = 0; b_never = 0;
    b_resp_k = 3'd0; r_resp_k = 3'd0;
    m3_axi_areset = 1'b1; mem_load = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 8'd0; cmd_wdata = 32'd0; cmd_wstrb = 4'd0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge m3_axi_aclk);
    mem_load = 1'b0;
    m3_axi_areset = 1'b0;

    // reset state: {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}
    check("reset_ctrl", 32'({cmd_ready, m3_axi_awvalid, m3_axi_wvalid, m3_axi_bready,
                             m3_axi_arvalid, m3_axi_rready, rsp_valid}), 32'b1000000);
    check("reset_rsp", 32'({rsp_we, rsp_resp}) | rsp_rdata, 32'd0);
    check("reset_addr", 32'({m3_axi_awaddr, m3_axi_wstrb}) | m3_axi_wdata, 32'd0);

    // 1: zero-wait write, minimum latency
    base_aw = n_aw; base_w = n_w; base_b = n_b;
    do_cmd(1'b1, 8'h00, 32'd25);
    wait_rsp(0, r_we, r_data, r_resp);
    $display("txn 1 write addr=0x00 data=25 resp=%0d", r_resp);
    check("t1_aw_edge", aw_cyc - acc_cyc, 32'd2);
    check("t1_w_edge", w_cyc - acc_cyc, 32'd2);
    check("t1_b_edge", b_cyc - acc_cyc, 32'd3);
    check("t1_rsp_first_seen", rsp_cyc - acc_cyc, 32'd5);
    check("t1_hs_counts", 32'((n_aw - base_aw) * 100 + (n_w - base_w) * 10 + (n_b - base_b)), 32'd111);
    check("t1_rsp", {r_we, 28'd0, r_resp}, 32'h8000_0000);
    check("t1_rdata", r_data, 32'd0);

    // 2: wready three cycles ahead of awready
    aw_lat = 3;
    base_aw = n_aw; base_w = n_w; base_b = n_b;
    do_cmd(1'b1, 8'h04, 32'd34);
    wait_rsp(0, r_we, r_data, r_resp);
    $display("txn 2 write addr=0x04 data=34 resp=%0d", r_resp);
    aw_lat = 0;
    check("t2_w_edge", w_cyc - acc_cyc, 32'd2);
    check("t2_aw_edge", aw_cyc - acc_cyc, 32'd5);
    check("t2_hs_counts", 32'((n_aw - base_aw) * 100 + (n_w - base_w) * 10 + (n_b - base_b)), 32'd111);
    check("t2_stability", 32'(stab_err), 32'd0);
    check("t2_resp", 32'({r_we, r_resp}), 32'b1000);

    // 3: read back 0x04, R delayed, response held for 5 cycles
    r_lat = 2;
    do_cmd(1'b0, 8'h04, 32'd0);
    wait_rsp(5, r_we, r_data, r_resp);
    $display("txn 3 read addr=0x04 data=%0d resp=%0d", r_data, r_resp);
    check("t3_araddr", 32'(ar_addr_seen), 32'h04);
    check("t3_ar_edge", ar_cyc - acc_cyc, 32'd2);
    check("t3_r_edge", r_cyc - acc_cyc, 32'd5);
    check("t3_rdata", r_data, 32'd34);
    check("t3_resp", 32'({r_we, r_resp}), 32'd0);

    // 4: read 0x08 with SLVERR after 4 wait cycles
    r_lat = 4; r_resp_k = 3'd2;
    do_cmd(1'b0, 8'h08, 32'd0);
    wait_rsp(0, r_we, r_data, r_resp);
    $display("txn 4 read addr=0x08 data=0x%0h resp=%0d", r_data, r_resp);
    r_lat = 0; r_resp_k = 3'd0;
    check("t4_r_edge", r_cyc - acc_cyc, 32'd7);
    check("t4_resp", 32'(r_resp), 32'd2);
    check("t4_rdata", r_data, 32'hA500_0002);

    // 5: B never arrives -> timeout after 16 WR_B cycles
    b_never = 1;
    base_b = n_b; base_bh = n_bready_hi;
    do_cmd(1'b1, 8'h0C, 32'h55);
    wait_rsp(0, r_we, r_data, r_resp);
    $display("txn 5 write addr=0x0C timeout resp=%0d", r_resp);
    b_never = 0;
    check("t5_bready_cycles", 32'(n_bready_hi - base_bh), 32'd16);
    check("t5_no_b_hs", 32'(n_b - base_b), 32'd0);
    check("t5_resp", 32'({r_we, r_resp}), 32'b1111);
    check("t5_rdata", r_data, 32'd0);

    // 6: next command after timeout runs normally
    do_cmd(1'b0, 8'h04, 32'd0);
    wait_rsp(0, r_we, r_data, r_resp);
    $display("txn 6 read addr=0x04 data=%0d resp=%0d", r_data, r_resp);
    check("t6_rdata", r_data, 32'd34);
    check("t6_resp", 32'(r_resp), 32'd0);

    // 7: B handshake lands in the expiry cycle -> real response wins
    b_lat = 15; b_resp_k = 3'd2;
    base_b = n_b;
    do_cmd(1'b1, 8'h10, 32'd7);
    wait_rsp(0, r_we, r_data, r_resp);
    $display("txn 7 write addr=0x10 late-B resp=%0d", r_resp);
    b_lat = 0; b_resp_k = 3'd0;
    check("t7_b_edge", b_cyc - acc_cyc, 32'd18);
    check("t7_b_count", 32'(n_b - base_b), 32'd1);
    check("t7_resp", 32'(r_resp), 32'd2);

    // 8: reset while AW/W are pending
    aw_lat = 50; w_lat = 50;
    base_rsp = n_rsp; base_b = n_b;
    do_cmd(1'b1, 8'h00, 32'd99);
    begin
      int n;
      n = 0;
      while (!m3_axi_awvalid && n < 10) begin @(negedge m3_axi_aclk); n++; end
    end
    check("t8_awvalid_before_reset", 32'(m3_axi_awvalid), 32'd1);
    m3_axi_areset = 1'b1;
    @(negedge m3_axi_aclk);
    m3_axi_areset = 1'b0;
    aw_lat = 0; w_lat = 0;
    check("t8_after_reset", 32'({cmd_ready, m3_axi_awvalid, m3_axi_wvalid, m3_axi_bready,
                                 m3_axi_arvalid, m3_axi_rready, rsp_valid}), 32'b1000000);
    repeat (8) @(negedge m3_axi_aclk);
    check("t8_no_rsp", 32'(n_rsp - base_rsp), 32'd0);
    $display("txn 8 write addr=0x00 data=99 abandoned by reset");
    do_cmd(1'b0, 8'h00, 32'd0);
    wait_rsp(0, r_we, r_data, r_resp);
    $display("txn 9 read addr=0x00 data=%0d resp=%0d", r_data, r_resp);
    check("t9_rdata", r_data, 32'd25);
    check("t9_stability", 32'(stab_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
